// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared pixel types, constants and helpers for the JPEG colour front end
// Purpose: pixel width, block size, converter pipeline depth, the {cr,cb,y}
//          pixel struct and an unsigned 8-bit saturation helper.
// Ports:   none (package).
package jpeg_pkg;

    localparam int PIX_W       = 24;
    localparam int BLK_PIX     = 64;
    localparam int CVT_LATENCY = 3;

    typedef struct packed {
        logic [7:0] cr;
        logic [7:0] cb;
        logic [7:0] y;
    } ycc_pixel_t;

    // Saturate a signed intermediate to the 0..255 range.
    function automatic logic [7:0] clamp_u8(input logic signed [26:0] v);
        logic [7:0] res;
        if (v < 27'sd0) begin
            res = 8'd0;
        end else if (v > 27'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb2ycrcb.sv
// rtl/rgb2ycrcb.sv - three-stage enable-gated RGB to YCbCr (full-range BT.601) converter
// Purpose: stage 1 registers the pixel, stage 2 forms 16-bit-fraction weighted
//          sums, stage 3 rounds and saturates. A pixel presented at enabled
//          edge k is on data_out after enabled edge k+2.
// Ports:   clk, rst (sync, active-high), enable (advance all stages)
//          data_in  {B,G,R}, data_out {Cr,Cb,Y}
module rgb2ycrcb
    import jpeg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [PIX_W-1:0]  data_in,
    output logic [PIX_W-1:0]  data_out
);

    logic [PIX_W-1:0]    r_px;
    logic signed [26:0]  r_y;
    logic signed [26:0]  r_cb;
    logic signed [26:0]  r_cr;
    ycc_pixel_t          r_out;

    logic signed [26:0]  w_r;
    logic signed [26:0]  w_g;
    logic signed [26:0]  w_b;
    logic signed [26:0]  w_y;
    logic signed [26:0]  w_cb;
    logic signed [26:0]  w_cr;

    assign w_r = $signed({19'd0, r_px[7:0]});
    assign w_g = $signed({19'd0, r_px[15:8]});
    assign w_b = $signed({19'd0, r_px[23:16]});

    // Coefficients scaled by 65536; each chroma row sums to zero so grey maps to 128.
    // The constant terms fold in the +128 chroma offset and the +0.5 rounding bias.
    assign w_y  = 27'sd19595 * w_r + 27'sd38470 * w_g + 27'sd7471 * w_b + 27'sd32768;
    assign w_cb = 27'sd32768 * w_b - 27'sd11059 * w_r - 27'sd21709 * w_g + 27'sd8421376;
    assign w_cr = 27'sd32768 * w_r - 27'sd27439 * w_g - 27'sd5329 * w_b + 27'sd8421376;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px  <= '0;
            r_y   <= '0;
            r_cb  <= '0;
            r_cr  <= '0;
            r_out <= '0;
        end else if (enable) begin
            r_px     <= data_in;
            r_y      <= w_y;
            r_cb     <= w_cb;
            r_cr     <= w_cr;
            r_out.y  <= clamp_u8(r_y >>> 16);
            r_out.cb <= clamp_u8(r_cb >>> 16);
            r_out.cr <= clamp_u8(r_cr >>> 16);
        end
    end

    assign data_out = r_out;

endmodule

// File: rtl/ycc_fifo.sv
// rtl/ycc_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
// Purpose: buffers converted pixels between the converter and the output stream.
// Ports:   clk, rst (sync, active-high)
//          wr_en, wr_data         write side
//          rd_en, rd_data         read side; rd_data valid whenever empty=0
//          empty, full, count     status
module ycc_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // A write while full is only legal when the head is leaving on the same edge.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rgb2ycbcr_ctrl.sv
// rtl/rgb2ycbcr_ctrl.sv - sequencer between an RGB pixel stream and the rgb2ycrcb converter
// Purpose: accepts pixels against FIFO credits, drives the converter enable,
//          tracks pixels in flight, collects results into an output FIFO and
//          tags them with 8x8-block and frame boundaries.
// Ports:   clk, rst (sync, active-high)
//          s_valid/s_ready/s_data          RGB input stream {B,G,R}
//          cvt_enable/cvt_data_in/out      converter interface
//          m_valid/m_ready/m_data          YCbCr output stream {Cr,Cb,Y}
//          m_last, m_frame_end             block / frame boundary tags
//          cfg_num_blocks                  blocks per frame (0 acts as 1)
//          busy                            work pending or frame incomplete
module rgb2ycbcr_ctrl
    import jpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    output logic              cvt_enable,
    output logic [PIX_W-1:0]  cvt_data_in,
    input  logic [PIX_W-1:0]  cvt_data_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_last,
    output logic              m_frame_end,
    input  logic [CNT_W-1:0]  cfg_num_blocks,
    output logic              busy
);

    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [5:0] PIX_LAST = 6'(BLK_PIX - 1);

    logic [CVT_LATENCY-1:0] r_vld;
    logic [5:0]             r_pix_cnt;
    logic [CNT_W-1:0]       r_blk_cnt;

    logic [CW-1:0]          w_fifo_count;
    logic [CW-1:0]          w_inflight;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_credit_ok;
    logic                   w_accept;
    logic                   w_fifo_wr;
    logic                   w_m_hs;
    logic [CNT_W-1:0]       w_blk_last;
    logic                   w_last;
    logic                   w_frame_end;

    // Every pixel in the converter already owns a FIFO slot, so a stalled
    // output can never force a converted pixel to be dropped.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < CVT_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end

    assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, w_inflight}) < DEPTH_C;
    assign s_ready     = w_credit_ok && !rst;
    assign w_accept    = s_valid && s_ready;
    assign cvt_data_in = s_data;

    // Enable on a new pixel or while anything is in flight; idle edges with an
    // empty pipe leave the converter frozen.
    assign cvt_enable  = w_accept || (|r_vld);
    assign w_fifo_wr   = cvt_enable && r_vld[CVT_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else if (cvt_enable) begin
            r_vld <= {r_vld[CVT_LATENCY-2:0], w_accept};
        end
    end

    ycc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_fifo_wr),
        .wr_data (cvt_data_out),
        .rd_en   (w_m_hs),
        .rd_data (m_data),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full),
        .count   (w_fifo_count)
    );

    assign m_valid = !w_fifo_empty;
    assign w_m_hs  = m_valid && m_ready;

    assign w_blk_last  = (cfg_num_blocks == '0) ? '0 : cfg_num_blocks - CNT_W'(1);
    assign w_last      = (r_pix_cnt == PIX_LAST);
    assign w_frame_end = w_last && (r_blk_cnt == w_blk_last);
    assign m_last      = m_valid && w_last;
    assign m_frame_end = m_valid && w_frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt <= '0;
            r_blk_cnt <= '0;
        end else if (w_m_hs) begin
            r_pix_cnt <= r_pix_cnt + 6'd1;
            if (w_last) begin
                r_blk_cnt <= w_frame_end ? '0 : r_blk_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (|r_vld) || (w_fifo_count != '0) || (r_pix_cnt != '0) || (r_blk_cnt != '0);

    a_no_write_when_full : assert property (@(posedge clk) disable iff (rst)
        w_fifo_wr |-> !w_fifo_full);

endmodule

// File: tb/tb_rgb2ycbcr_ctrl.sv
// tb/tb_rgb2ycbcr_ctrl.sv - randomized scoreboard bench for rgb2ycbcr_ctrl with rgb2ycrcb
module tb_rgb2ycbcr_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [23:0]       s_data = '0;
    logic              cvt_enable;
    logic [23:0]       cvt_data_in;
    logic [23:0]       cvt_data_out;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [23:0]       m_data;
    logic              m_last;
    logic              m_frame_end;
    logic [CNT_W-1:0]  cfg_num_blocks = 16'd1;
    logic              busy;

    always #5 clk = ~clk;

    rgb2ycrcb u_cvt (
        .clk      (clk),
        .rst      (rst),
        .enable   (cvt_enable),
        .data_in  (cvt_data_in),
        .data_out (cvt_data_out)
    );

    rgb2ycbcr_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .cvt_enable     (cvt_enable),
        .cvt_data_in    (cvt_data_in),
        .cvt_data_out   (cvt_data_out),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_frame_end    (m_frame_end),
        .cfg_num_blocks (cfg_num_blocks),
        .busy           (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [23:0] exp_q[$];
    int          out_pos = 0;
    int          n_out, n_last, n_fe, first_acc, first_out, last_out;
    logic [23:0] first_data;
    logic        first_cvt_en;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Full-range BT.601 with coefficients in 1/65536 units, round half up, saturate.
    function automatic logic [23:0] ref_ycc(input logic [23:0] bgr);
        int r, g, b, y, cb, cr;
        logic [7:0] y8, cb8, cr8;
        r  = int'(bgr[7:0]);
        g  = int'(bgr[15:8]);
        b  = int'(bgr[23:16]);
        y  = (19595 * r + 38470 * g + 7471 * b + 32768) / 65536;
        cb = (32768 * b - 11059 * r - 21709 * g + 128 * 65536 + 32768) / 65536;
        cr = (32768 * r - 27439 * g - 5329 * b + 128 * 65536 + 32768) / 65536;
        if (y  > 255) y  = 255;
        if (cb > 255) cb = 255;
        if (cr > 255) cr = 255;
        y8  = y[7:0];
        cb8 = cb[7:0];
        cr8 = cr[7:0];
        return {cr8, cb8, y8};
    endfunction

    function automatic int frame_len();
        return (cfg_num_blocks == 0 ? 1 : int'(cfg_num_blocks)) * 64;
    endfunction

    // Scoreboard: every accepted pixel is queued as its expected result; every
    // output handshake must match the queue head and the frame position tags.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            out_pos = 0;
            check("s_ready_in_rst", s_ready, 0);
        end else begin
            check("busy", busy, (exp_q.size() != 0 || out_pos != 0));
            if (m_valid) begin
                if (first_out < 0) begin
                    first_out    = cyc;
                    first_data   = m_data;
                    first_cvt_en = cvt_enable;
                end
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL m_valid_unexpected: got m_data %0h expected no output (cycle %0d)", m_data, cyc);
                end else begin
                    check("m_data", m_data, exp_q[0]);
                    check("m_last", m_last, (out_pos % 64) == 63);
                    check("m_frame_end", m_frame_end, out_pos == frame_len() - 1);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        out_pos = (out_pos + 1) % frame_len();
                        n_out++;
                        last_out = cyc;
                        if (m_last) n_last++;
                        if (m_frame_end) n_fe++;
                    end
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(ref_ycc(s_data));
                if (first_acc < 0) first_acc = cyc;
            end
        end
    end

    task automatic clear_stats();
        n_out = 0; n_last = 0; n_fe = 0;
        first_acc = -1; first_out = -1; last_out = -1;
    endtask

    function automatic logic [23:0] gen_pix(input int idx, input int mode);
        logic [7:0] k;
        k = idx[7:0];
        case (mode)
            0:       return {k, k, k};
            2:       return 24'h0000FF;
            default: return 24'($urandom);
        endcase
    endfunction

    // Drives up to n pixels, holding s_valid/s_data until each handshake.
    task automatic stream(input int n, input int vprob, input int rprob, input int mode,
                          input int maxcyc, output int sent);
        logic fired;
        int   k;
        sent  = 0;
        fired = 1'b0;
        k     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fired) sent++;
            if (sent >= n || k >= maxcyc) break;
            if (!s_valid || fired) begin
                s_valid = ($urandom_range(99) < vprob);
                s_data  = gen_pix(sent, mode);
            end
            m_ready = ($urandom_range(99) < rprob);
            @(negedge clk);
            fired = s_valid && s_ready;
            k++;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input int maxcyc);
        int k;
        m_ready = 1'b1;
        s_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (busy && k < maxcyc) begin
            @(negedge clk);
            k++;
        end
        check("drain_idle", busy, 0);
        check("idle_cvt_enable", cvt_enable, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        clear_stats();
        first_data   = '0;
        first_cvt_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_frame_end", m_frame_end, 0);
        check("rst_cvt_enable", cvt_enable, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: grey ramp at full throughput
        cfg_num_blocks = 16'd1;
        clear_stats();
        stream(64, 100, 100, 0, 200, sent);
        drain(200);
        check("t1_sent", sent, 64);
        check("t1_latency", first_out - first_acc, 4);
        check("t1_back_to_back", last_out - first_out, 63);
        check("t1_first_pixel", first_data, 24'h808000);
        check("t1_n_out", n_out, 64);
        check("t1_n_last", n_last, 1);
        check("t1_n_frame_end", n_fe, 1);

        // 2: single red pixel then flush
        clear_stats();
        stream(1, 100, 100, 2, 50, sent);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && first_out < 0; i++) @(negedge clk);
        check("t2_red_pixel", first_data, 24'hFF554C);
        check("t2_cvt_enable_after_flush", first_cvt_en, 0);
        @(posedge clk);
        #1;
        stream(63, 100, 100, 0, 300, sent);
        drain(200);
        check("t2_n_out", n_out, 64);
        check("t2_n_frame_end", n_fe, 1);

        // 3: output stalled, credits limit acceptance
        clear_stats();
        stream(20, 100, 0, 0, 20, sent);
        check("t3_accepted_while_stalled", sent, FIFO_DEPTH);
        @(negedge clk);
        check("t3_s_ready_stalled", s_ready, 0);
        @(posedge clk);
        #1;
        stream(56, 100, 100, 1, 300, sent);
        drain(200);
        check("t3_n_out", n_out, 64);
        check("t3_n_last", n_last, 1);

        // 4: two-block frame with random handshakes
        cfg_num_blocks = 16'd2;
        clear_stats();
        stream(128, 70, 60, 1, 3000, sent);
        drain(500);
        check("t4_sent", sent, 128);
        check("t4_n_out", n_out, 128);
        check("t4_n_last", n_last, 2);
        check("t4_n_frame_end", n_fe, 1);

        // 5: reset mid-frame, then a clean frame
        cfg_num_blocks = 16'd1;
        clear_stats();
        stream(30, 100, 50, 1, 300, sent);
        check("t5_sent_before_rst", sent, 30);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_m_valid_after_rst", m_valid, 0);
        check("t5_busy_after_rst", busy, 0);
        @(posedge clk);
        #1;
        clear_stats();
        stream(64, 80, 80, 1, 2000, sent);
        drain(300);
        check("t5_n_out", n_out, 64);
        check("t5_n_last", n_last, 1);
        check("t5_n_frame_end", n_fe, 1);

        // 6: zero blocks behaves as one
        cfg_num_blocks = 16'd0;
        clear_stats();
        stream(64, 90, 90, 1, 2000, sent);
        drain(300);
        check("t6_n_out", n_out, 64);
        check("t6_n_last", n_last, 1);
        check("t6_n_frame_end", n_fe, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
